// File: rtl/fir_pkg.sv
// Shared FIR accelerator types: sample, qualified sample bus and rate field.
package fir_pkg;
    typedef logic signed [15:0] FIR_DATA_SAMPLE;
    typedef struct packed {
        FIR_DATA_SAMPLE data;
        logic           valid;
    } FIR_DATA_BUS;
    typedef logic [7:0] FIR_UP_RATE;
endpackage

// File: rtl/stream_master_decim.sv
// Output AXI4-Stream master: decimates the FIR sample stream, queues kept samples, drives TLAST.
// Optional overflow reporting (ovf, ovf_cnt) is enabled with `define FIR_STREAM_MASTER_OVF_EN.
module stream_master_decim
    import fir_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = $bits(FIR_DATA_SAMPLE),
    parameter int DEPTH                = 16,
    parameter int SKID                 = 12
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESET,
    input  FIR_DATA_BUS                         fir_out,
    input  logic                                last_in,
    input  FIR_UP_RATE                          rate,
    output logic                                is_ready,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,
    output logic                                ovf,
    output logic [15:0]                         ovf_cnt
);
    localparam int W  = C_M_AXIS_TDATA_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    function automatic logic signed [W-1:0] ext_sample(input FIR_DATA_SAMPLE s);
        return W'(s);
    endfunction

    FIR_UP_RATE     ph;
    FIR_UP_RATE     rate_q;
    FIR_UP_RATE     rate_eff;
    logic           pkt_start;
    logic           beat, keep, push, pop, full, drop;
    logic [W:0]     mem [DEPTH];
    logic [W:0]     head;
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  cnt;

    // A new packet takes the live rate on its first beat; later beats use the latched copy.
    always_comb begin
        beat     = fir_out.valid;
        rate_eff = pkt_start ? rate : rate_q;
        keep     = beat && ((ph == '0) || last_in);
        pop      = (cnt != '0) && M_AXIS_TREADY;
        full     = (cnt == CW'(DEPTH));
        push     = keep && (!full || pop);
        drop     = keep && full && !pop;
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            ph        <= '0;
            rate_q    <= '0;
            pkt_start <= 1'b1;
        end else if (beat) begin
            if (pkt_start)
                rate_q <= rate;
            pkt_start <= last_in;
            if (last_in || (ph == rate_eff))
                ph <= '0;
            else
                ph <= ph + FIR_UP_RATE'(1);
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (push)
            mem[wr_ptr] <= {ext_sample(fir_out.data), last_in};
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Output is gated by occupancy so an empty queue never exposes stale or unwritten entries.
    always_comb begin
        head          = mem[rd_ptr];
        M_AXIS_TVALID = (cnt != '0);
        M_AXIS_TDATA  = M_AXIS_TVALID ? head[W:1] : '0;
        M_AXIS_TLAST  = M_AXIS_TVALID && head[0];
        M_AXIS_TSTRB  = '1;
        is_ready      = ((CW'(DEPTH) - cnt) >= CW'(SKID));
    end

`ifdef FIR_STREAM_MASTER_OVF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (drop) begin
            ovf     <= 1'b1;
            ovf_cnt <= sat_inc16(ovf_cnt);
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign ovf         = 1'b0;
    assign ovf_cnt     = '0;
`endif
endmodule

// File: tb/tb_stream_master_decim.sv
// Directed bench for stream_master_decim: decimation, TLAST, backpressure, overflow, reset.
module tb_stream_master_decim;
    import fir_pkg::*;

    localparam int DEPTH = 16;
    localparam int SKID  = 12;

    logic        clk = 1'b0;
    logic        rst;
    FIR_DATA_BUS fir_out;
    logic        last_in;
    FIR_UP_RATE  rate;
    logic        is_ready;
    logic        tvalid;
    logic [15:0] tdata;
    logic [1:0]  tstrb;
    logic        tlast;
    logic        tready;
    logic        ovf;
    logic [15:0] ovf_cnt;

    int errors = 0;
    int checks = 0;
    int kept_n;
    int drops;
    bit kept;

    always #5 clk = ~clk;

    stream_master_decim #(.DEPTH(DEPTH), .SKID(SKID)) dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESET (rst),
        .fir_out       (fir_out),
        .last_in       (last_in),
        .rate          (rate),
        .is_ready      (is_ready),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TSTRB  (tstrb),
        .M_AXIS_TLAST  (tlast),
        .M_AXIS_TREADY (tready),
        .ovf           (ovf),
        .ovf_cnt       (ovf_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] d, input logic l);
        fir_out.valid = v;
        fir_out.data  = FIR_DATA_SAMPLE'(d);
        last_in       = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        fir_out = '0;
        last_in = 1'b0;
        rate    = '0;
        tready  = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tstrb", tstrb, 2'b11);
        chk("rst_ovf", ovf, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        chk("rst_is_ready", is_ready, 1);
        chk("rst_cnt", dut.cnt, 0);
        rst = 1'b0;

        // rate 3: keep 1,5,9 and the last beat 12
        rate   = 8'd3;
        tready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc(1, 16'(k), k == 12);
            kept = (k % 4 == 1) || (k == 12);
            chk("t1_tvalid", tvalid, kept);
            if (kept) begin
                chk("t1_tdata", tdata, k);
                chk("t1_tlast", tlast, k == 12);
            end
        end
        cyc(0, 0, 0);
        chk("t1_idle", tvalid, 0);

        // rate 0: pass-through at one word per cycle
        rate = 8'd0;
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 16'(16'h30 + k), k == 8);
            chk("t2_tvalid", tvalid, 1);
            chk("t2_tdata", tdata, 16'h30 + k);
            chk("t2_tlast", tlast, k == 8);
            chk("t2_cnt", dut.cnt, 1);
        end
        cyc(0, 0, 0);
        chk("t2_idle", tvalid, 0);

        // rate 2 with TREADY low: fill, lose is_ready, then overflow
        rate   = 8'd2;
        tready = 1'b0;
        kept_n = 0;
        drops  = 0;
        for (int b = 1; b <= 54; b++) begin
            cyc(1, 16'(b), 0);
            if ((b - 1) % 3 == 0) begin
                if (kept_n < DEPTH) kept_n++;
                else drops++;
            end
            chk("t3_cnt", dut.cnt, kept_n);
            chk("t3_is_ready", is_ready, (DEPTH - kept_n) >= SKID);
            chk("t3_tvalid", tvalid, 1);
            chk("t3_head_stable", tdata, 1);
        end
        chk("t3_drops", drops, 2);
`ifdef FIR_STREAM_MASTER_OVF_EN
        chk("t3_ovf", ovf, 1);
        chk("t3_ovf_cnt", ovf_cnt, 2);
`else
        chk("t3_ovf", ovf, 0);
        chk("t3_ovf_cnt", ovf_cnt, 0);
`endif

        // full FIFO, pop and kept beat together: accepted, no drop
        tready = 1'b1;
        cyc(1, 16'd55, 0);
        chk("t4_cnt_full", dut.cnt, DEPTH);
        chk("t4_head", tdata, 4);
`ifdef FIR_STREAM_MASTER_OVF_EN
        chk("t4_ovf_cnt", ovf_cnt, 2);
`else
        chk("t4_ovf_cnt", ovf_cnt, 0);
`endif
        for (int j = 0; j < DEPTH; j++) begin
            chk("t4_drain_tvalid", tvalid, 1);
            chk("t4_drain_tdata", tdata, (j < DEPTH - 1) ? 4 + 3 * j : 55);
            chk("t4_drain_tlast", tlast, 0);
            cyc(0, 0, 0);
        end
        chk("t4_empty_tvalid", tvalid, 0);
        chk("t4_empty_cnt", dut.cnt, 0);
        cyc(1, 16'd99, 1);
        chk("t4_end_tdata", tdata, 99);
        chk("t4_end_tlast", tlast, 1);
        cyc(0, 0, 0);
        chk("t4_end_idle", tvalid, 0);

        // rate change mid-packet ignored until the next packet
        rate = 8'd1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) rate = 8'd3;
            cyc(1, 16'(16'h40 + k), k == 8);
            kept = (k % 2 == 1) || (k == 8);
            chk("t5a_tvalid", tvalid, kept);
            if (kept) begin
                chk("t5a_tdata", tdata, 16'h40 + k);
                chk("t5a_tlast", tlast, k == 8);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 16'(16'h50 + k), k == 8);
            kept = (k % 4 == 1) || (k == 8);
            chk("t5b_tvalid", tvalid, kept);
            if (kept) begin
                chk("t5b_tdata", tdata, 16'h50 + k);
                chk("t5b_tlast", tlast, k == 8);
            end
        end
        cyc(0, 0, 0);
        chk("t5_idle", tvalid, 0);

        // five words queued, then reset mid-packet
        rate   = 8'd0;
        tready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 16'(16'h60 + k), 0);
            chk("t6_cnt", dut.cnt, k);
            chk("t6_is_ready", is_ready, (DEPTH - k) >= SKID);
        end
        rst = 1'b1;
        cyc(0, 0, 0);
        chk("t6_rst_tvalid", tvalid, 0);
        chk("t6_rst_cnt", dut.cnt, 0);
        chk("t6_rst_tdata", tdata, 0);
        chk("t6_rst_tlast", tlast, 0);
        chk("t6_rst_is_ready", is_ready, 1);
        chk("t6_rst_ovf", ovf, 0);
        chk("t6_rst_ovf_cnt", ovf_cnt, 0);
        rst    = 1'b0;
        rate   = 8'd1;
        tready = 1'b1;
        for (int d = 20; d <= 23; d++) begin
            cyc(1, 16'(d), d == 23);
            kept = (d != 21);
            chk("t6_tvalid", tvalid, kept);
            if (kept) begin
                chk("t6_tdata", tdata, d);
                chk("t6_tlast", tlast, d == 23);
            end
        end
        cyc(0, 0, 0);
        chk("t6_idle", tvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
